// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller slice: state
// encodings, coin codes with their quarter values, and default prices.
package vend_pkg;

   localparam int CREDIT_W            = 4;
   localparam int MAX_CREDIT_DEF      = 8;
   localparam int PRICE_A_DEF         = 5;
   localparam int PRICE_B_DEF         = 6;
   localparam int DISPENSE_CYCLES_DEF = 4;
   localparam int CHANGE_GAP_DEF      = 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COIN_HOLD = 3'd1,
      ST_DISPENSE  = 3'd2,
      ST_CHANGE_HI = 3'd3,
      ST_CHANGE_LO = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      COIN_25C = 2'b00,
      COIN_50C = 2'b01,
      COIN_1D  = 2'b10,
      COIN_BAD = 2'b11
   } coin_t;

   // Quarter value of a coin code; the invalid code is worth nothing.
   function automatic logic [2:0] coin_quarters(input logic [1:0] code);
      logic [2:0] q;
      case (code)
         COIN_25C: q = 3'd1;
         COIN_50C: q = 3'd2;
         COIN_1D:  q = 3'd4;
         default:  q = 3'd0;
      endcase
      return q;
   endfunction

   function automatic logic coin_is_valid(input logic [1:0] code);
      return (code != COIN_BAD);
   endfunction

endpackage

// File: rtl/vend_if.sv
// Front-panel bundle of the vending controller: coin/button inputs and the
// credit, dispense, change and debug outputs. The panel side is the master,
// the controller is the slave.
interface vend_if;
   import vend_pkg::*;

   logic                coin_in;
   logic [1:0]          coin_val;
   logic                sel_a;
   logic                sel_b;
   logic                cancel;
   logic [CREDIT_W-1:0] credit;
   logic                dispense_a;
   logic                dispense_b;
   logic                change_pulse;
   logic                invalid_coin;
   logic                busy;
   logic [2:0]          state_now;

   modport master (
      output coin_in, coin_val, sel_a, sel_b, cancel,
      input  credit, dispense_a, dispense_b, change_pulse, invalid_coin,
             busy, state_now
   );

   modport slave (
      input  coin_in, coin_val, sel_a, sel_b, cancel,
      output credit, dispense_a, dispense_b, change_pulse, invalid_coin,
             busy, state_now
   );

endinterface

// File: rtl/coin_edge_detect.sv
// Turns the coin-present level into a single-cycle insert strobe. The coin
// code is presented alongside the strobe so the consumer samples it on the
// same edge; it reads as the 25c code whenever no strobe is active.
module coin_edge_detect
   import vend_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_in,
   input  logic [1:0] coin_val,
   output logic       coin_edge,
   output logic [1:0] coin_code
);

   logic coin_prev;

   // Previous coin level, cleared by reset so a coin held through reset
   // registers as a fresh insert once reset is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         coin_prev <= 1'b0;
      end else begin
         coin_prev <= coin_in;
      end
   end

   assign coin_edge = coin_in & ~coin_prev;
   assign coin_code = coin_edge ? coin_val : COIN_25C;

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: owns the credit register, product release and change
// return. Credit is kept in quarters; every output is registered except the
// debug state view, which is the state register itself.
module vend_controller
   import vend_pkg::*;
#(
   parameter int MAX_CREDIT      = MAX_CREDIT_DEF,
   parameter int PRICE_A         = PRICE_A_DEF,
   parameter int PRICE_B         = PRICE_B_DEF,
   parameter int DISPENSE_CYCLES = DISPENSE_CYCLES_DEF,
   parameter int CHANGE_GAP      = CHANGE_GAP_DEF
) (
   input  logic   clk,
   input  logic   rst,
   vend_if.slave  bus
);

   localparam logic [CREDIT_W-1:0] PRICE_A_Q  = CREDIT_W'(PRICE_A);
   localparam logic [CREDIT_W-1:0] PRICE_B_Q  = CREDIT_W'(PRICE_B);
   localparam logic [CREDIT_W:0]   MAX_SUM_Q  = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [3:0]          DISP_LAST  = 4'(DISPENSE_CYCLES - 1);
   localparam logic [3:0]          GAP_LAST   = 4'(CHANGE_GAP - 1);

   state_t              state;
   logic [CREDIT_W-1:0] credit_q;
   logic [3:0]          cnt;
   logic                dispense_a_q;
   logic                dispense_b_q;
   logic                change_pulse_q;
   logic                invalid_coin_q;
   logic                busy_q;

   logic                coin_edge;
   logic [1:0]          coin_code;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_ok;

   coin_edge_detect u_edge (
      .clk       (clk),
      .rst       (rst),
      .coin_in   (bus.coin_in),
      .coin_val  (bus.coin_val),
      .coin_edge (coin_edge),
      .coin_code (coin_code)
   );

   // Candidate credit after the presented coin, one bit wider so an
   // over-ceiling insert is seen rather than wrapped.
   assign coin_sum = {1'b0, credit_q} + {2'b00, coin_quarters(coin_code)};
   assign coin_ok  = coin_is_valid(coin_code) && (coin_sum <= MAX_SUM_Q);

   // Main sequencer: state, credit and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         credit_q       <= '0;
         cnt            <= '0;
         dispense_a_q   <= 1'b0;
         dispense_b_q   <= 1'b0;
         change_pulse_q <= 1'b0;
         invalid_coin_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         invalid_coin_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (coin_edge) begin
                  if (coin_ok) begin
                     credit_q <= coin_sum[CREDIT_W-1:0];
                  end else begin
                     invalid_coin_q <= 1'b1;
                  end
                  state  <= ST_COIN_HOLD;
                  busy_q <= 1'b1;
               end else if (bus.cancel && (credit_q != '0)) begin
                  state          <= ST_CHANGE_HI;
                  change_pulse_q <= 1'b1;
                  busy_q         <= 1'b1;
               end else if (bus.sel_a && (credit_q >= PRICE_A_Q)) begin
                  state        <= ST_DISPENSE;
                  credit_q     <= credit_q - PRICE_A_Q;
                  dispense_a_q <= 1'b1;
                  cnt          <= DISP_LAST;
                  busy_q       <= 1'b1;
               end else if (bus.sel_b && (credit_q >= PRICE_B_Q)) begin
                  state        <= ST_DISPENSE;
                  credit_q     <= credit_q - PRICE_B_Q;
                  dispense_b_q <= 1'b1;
                  cnt          <= DISP_LAST;
                  busy_q       <= 1'b1;
               end
            end

            // The coin is still in the slot; buttons are deliberately ignored.
            ST_COIN_HOLD: begin
               if (!bus.coin_in) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end

            ST_DISPENSE: begin
               if (coin_edge) begin
                  invalid_coin_q <= 1'b1;
               end
               if (cnt == '0) begin
                  dispense_a_q <= 1'b0;
                  dispense_b_q <= 1'b0;
                  if (credit_q != '0) begin
                     state          <= ST_CHANGE_HI;
                     change_pulse_q <= 1'b1;
                  end else begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            // One quarter leaves on the edge that ends the pulse.
            ST_CHANGE_HI: begin
               if (coin_edge) begin
                  invalid_coin_q <= 1'b1;
               end
               change_pulse_q <= 1'b0;
               credit_q       <= credit_q - 1'b1;
               cnt            <= GAP_LAST;
               state          <= ST_CHANGE_LO;
            end

            ST_CHANGE_LO: begin
               if (coin_edge) begin
                  invalid_coin_q <= 1'b1;
               end
               if (cnt == '0) begin
                  if (credit_q != '0) begin
                     state          <= ST_CHANGE_HI;
                     change_pulse_q <= 1'b1;
                  end else begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            default: begin
               state          <= ST_IDLE;
               busy_q         <= 1'b0;
               dispense_a_q   <= 1'b0;
               dispense_b_q   <= 1'b0;
               change_pulse_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.credit       = credit_q;
   assign bus.dispense_a   = dispense_a_q;
   assign bus.dispense_b   = dispense_b_q;
   assign bus.change_pulse = change_pulse_q;
   assign bus.invalid_coin = invalid_coin_q;
   assign bus.busy         = busy_q;
   assign bus.state_now    = state;

endmodule

// File: tb/tb_vend_controller.sv
// Directed and randomized checks of vend_controller against a transaction
// level model: credit arithmetic plus the expected per-cycle output trace
// of each purchase or refund.
module tb_vend_controller;

   logic clk;
   logic rst;

   vend_if bus ();

   vend_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int credit_m = 0;

   localparam int MAXC  = 8;
   localparam int PA    = 5;
   localparam int PB    = 6;
   localparam int DCYC  = 4;
   localparam int GAP   = 1;

   // Observation vector: {invalid, disp_a, disp_b, change, busy, credit, state}
   function automatic logic [11:0] obs();
      return {bus.invalid_coin, bus.dispense_a, bus.dispense_b,
              bus.change_pulse, bus.busy, bus.credit, bus.state_now};
   endfunction

   function automatic logic [11:0] mk(input logic inv, input logic da,
                                      input logic db, input logic cp,
                                      input logic bz, input int cr,
                                      input int st);
      return {inv, da, db, cp, bz, 4'(cr), 3'(st)};
   endfunction

   task automatic check(input string tag, input logic [11:0] o,
                        input logic [11:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.coin_in = 1'b0; bus.coin_val = 2'b00;
      bus.sel_a = 1'b0; bus.sel_b = 1'b0; bus.cancel = 1'b0;
      step();
      step();
      check("reset", obs(), mk(0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;
      credit_m = 0;
   endtask

   // Insert one coin, holding coin_in high for 'hold' cycles.
   task automatic coin(input logic [1:0] code, input int hold);
      int q;
      int nc;
      logic ok;
      q  = (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : (code == 2'd2) ? 4 : 0;
      ok = (code != 2'd3) && (credit_m + q <= MAXC);
      nc = ok ? credit_m + q : credit_m;
      bus.coin_val = code;
      bus.coin_in  = 1'b1;
      step();
      check("coin_edge", obs(), mk(!ok, 0, 0, 0, 1, nc, 1));
      for (int i = 1; i < hold; i++) begin
         step();
         check("coin_hold", obs(), mk(0, 0, 0, 0, 1, nc, 1));
      end
      bus.coin_in = 1'b0;
      step();
      check("coin_release", obs(), mk(0, 0, 0, 0, 0, nc, 0));
      credit_m = nc;
   endtask

   // One button cycle (sel_a/sel_b/cancel), then follow the expected trace.
   // inject_idx >= 0 raises a coin after that trace cycle; -2 picks one at random.
   task automatic vend(input logic a, input logic b, input logic c,
                       input int inject_idx);
      logic [11:0] exp_q[$];
      int k;
      int prod;
      int inj;
      k    = credit_m;
      prod = 0;
      if (c && k > 0)        prod = 3;
      else if (a && k >= PA) prod = 1;
      else if (b && k >= PB) prod = 2;
      exp_q.delete();
      if (prod == 1 || prod == 2) begin
         k -= (prod == 1) ? PA : PB;
         repeat (DCYC) exp_q.push_back(mk(0, prod == 1, prod == 2, 0, 1, k, 2));
      end
      if (prod != 0) begin
         while (k > 0) begin
            exp_q.push_back(mk(0, 0, 0, 1, 1, k, 3));
            k--;
            repeat (GAP) exp_q.push_back(mk(0, 0, 0, 0, 1, k, 4));
         end
      end
      inj = inject_idx;
      if (inj == -2)
         inj = (exp_q.size() >= 2) ? int'($urandom_range(0, exp_q.size() - 2)) : -1;
      if (inj >= 0 && inj + 1 < exp_q.size()) exp_q[inj + 1][11] = 1'b1;
      else inj = -1;

      bus.sel_a = a; bus.sel_b = b; bus.cancel = c;
      step();
      bus.sel_a = 1'b0; bus.sel_b = 1'b0; bus.cancel = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         check("trace", obs(), exp_q[i]);
         if (i == inj) begin
            bus.coin_val = 2'($urandom_range(0, 3));
            bus.coin_in  = 1'b1;
         end else begin
            bus.coin_in  = 1'b0;
         end
         step();
      end
      bus.coin_in = 1'b0;
      if (prod != 0) credit_m = 0;
      check("vend_end", obs(), mk(0, 0, 0, 0, 0, credit_m, 0));
   endtask

   initial begin
      rst = 1'b1;
      bus.coin_in = 1'b0; bus.coin_val = 2'b00;
      bus.sel_a = 1'b0; bus.sel_b = 1'b0; bus.cancel = 1'b0;

      // 25c held for five cycles counts once
      do_reset();
      coin(2'b00, 5);

      // $1 + 50c + 25c, buy A, two quarters back
      do_reset();
      coin(2'b10, 2);
      coin(2'b01, 1);
      coin(2'b00, 3);
      vend(1'b1, 1'b0, 1'b0, -1);

      // over-ceiling and invalid coins are rejected
      do_reset();
      coin(2'b10, 1);
      coin(2'b01, 1);
      coin(2'b10, 2);
      coin(2'b11, 1);

      // insufficient B is ignored, then cancel refunds three quarters
      do_reset();
      coin(2'b01, 1);
      coin(2'b00, 1);
      vend(1'b0, 1'b1, 1'b0, -1);
      vend(1'b0, 1'b0, 1'b1, -1);
      vend(1'b0, 1'b0, 1'b1, -1);

      // full credit, both buttons: A wins; coin during the first change gap
      do_reset();
      coin(2'b10, 1);
      coin(2'b10, 1);
      vend(1'b1, 1'b1, 1'b0, 5);

      // reset in the second dispense cycle loses everything
      do_reset();
      coin(2'b10, 1);
      coin(2'b00, 1);
      bus.sel_a = 1'b1;
      step();
      bus.sel_a = 1'b0;
      check("rst_disp1", obs(), mk(0, 1, 0, 0, 1, 0, 2));
      step();
      check("rst_disp2", obs(), mk(0, 1, 0, 0, 1, 0, 2));
      rst = 1'b1;
      step();
      check("rst_abort", obs(), mk(0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;
      credit_m = 0;

      // randomized mix of coins, purchases and refunds
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0, 1, 2: coin(2'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            3: vend(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -2);
            default: vend(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'b1, -2);
         endcase
         repeat ($urandom_range(0, 2)) begin
            step();
            check("idle_gap", obs(), mk(0, 0, 0, 0, 0, credit_m, 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
